cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Shares the `CDBWidth` common-data-bus lanes between `NumRequesters` functional-unit result ports using round-robin priority.
- Each cycle it grants up to `CDBWidth` pending results with a valid/ready handshake and registers the winners onto the CDB.
- It sits between the execution units and the reorder buffer / reservation stations, which sample `cdb_valid_o`/`cdb_tag_o`/`cdb_data_o`.
- It drops results on a pipeline flush.

## Interface

Parameters:
- `NumRequesters`, 4, number of functional-unit result ports; must be ≥ 2 and ≥ `CDBWidth`.
- `CDBWidth`, 2, number of CDB lanes; must be ≥ 1.
- `PhyRegIDWidth`, 6, tag width.
- `DatapathWidth`, 32, result data width.

Ports (unpacked arrays indexed `[N-1:0]`):
- `clk_i` input 1: the only clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `flush_i` input 1: pipeline flush; discard all in-flight and requested results.
- `req_valid_i` input `[NumRequesters]` x 1: requester i holds a result.
- `req_tag_i` input `[NumRequesters]` x `PhyRegIDWidth`: destination physical tag.
- `req_data_i` input `[NumRequesters]` x `DatapathWidth`: result value.
- `req_ready_o` output `[NumRequesters]` x 1: grant. A transfer occurs when valid and ready are both high in the same cycle.
- `cdb_valid_o` output `CDBWidth`: lane k carries a result.
- `cdb_tag_o` output `[CDBWidth]` x `PhyRegIDWidth`: lane tag.
- `cdb_data_o` output `[CDBWidth]` x `DatapathWidth`: lane data.

## Operation

- State:
  - Round-robin pointer `rr_q`, width `$clog2(NumRequesters)`, range 0..`NumRequesters-1`.
  - Registered lane outputs (valid, tag, data per lane).
- Selection is combinational each cycle:
  - Scan requesters in order `rr_q, rr_q+1, …` wrapping modulo `NumRequesters`. Wrap must work for non-power-of-two counts.
  - The first `CDBWidth` requesters with `req_valid_i` high win.
  - The j-th winner in scan order goes to lane j.
  - `req_ready_o[i]` is high only for winners.
  - `req_ready_o` never depends on `req_valid_i` of a non-winner.
- Lane load:
  - Lane j is loaded with the j-th winner's tag and data; `cdb_valid_o[j]` is set next cycle.
  - Unused lanes are loaded with valid 0, tag 0, data 0.
- Pointer update:
  - With ≥ 1 winner, `rr_q` becomes (index of last winner + 1) mod `NumRequesters`.
  - With no winner, `rr_q` holds.
- Fairness: a requester that holds valid high continuously is granted within `ceil(NumRequesters/CDBWidth)` cycles.
- Requesters must keep valid, tag and data stable until granted. The arbiter does not check this.
- Flush (`flush_i` high in cycle t):
  - `req_ready_o` is all zero in t.
  - All lanes are written invalid, so `cdb_valid_o` is 0 at t+1.
  - `rr_q` holds.
  - Lanes already valid during t are not retracted; consumers ignore them per their own flush handling.
- Reset (`rst_i` high at an edge):
  - `rr_q` = 0; `cdb_valid_o` = 0; `cdb_tag_o` and `cdb_data_o` = 0.
  - While `rst_i` is high, `req_ready_o` is forced to 0, so no handshake completes.
  - Reset asserted mid-stream discards all pending lane contents.
- Reset has priority over flush.

## Timing

- Grant to CDB latency is exactly 1 cycle: handshake in cycle t puts the result on the lane in t+1, valid for exactly one cycle unless regranted.
- Throughput: up to `CDBWidth` results per cycle, back-to-back, with no bubbles.
- `req_ready_o` is combinational from `req_valid_i`, `rr_q`, `flush_i` and `rst_i`. There is no path from `req_tag_i`/`req_data_i` to `req_ready_o`.
- All outputs except `req_ready_o` are registered.

## Structure

- Shared package `cdb_pkg`:
  - Default width constants (`PhyRegIDWidth`, `DatapathWidth`, `CDBWidth`).
  - Parameterized lane struct (valid/tag/data) for reuse by the reorder buffer and reservation stations.
- Sub-module `cdb_rr_pick`:
  - Given a request mask and a start index, returns a one-hot of the first set bit at or after the start, with wrap.
  - Instantiated `CDBWidth` times in a chain. Each stage masks out the previous winners and uses the same start index.

## Test plan

- **Reset:** hold `rst_i` 3 cycles with all `req_valid_i`=1 → `req_ready_o`=0 throughout. Cycle after release: `cdb_valid_o`=00. Next cycle: requesters 0,1 granted.
- **Round-robin:** `NumRequesters`=4, `CDBWidth`=2, all valid continuously →
  - grants {0,1}, {2,3}, {0,1} on consecutive cycles;
  - lane 0 tags are 0,2,0 one cycle later (set tag = requester index).
- **Sparse and wrap:** `rr_q`=3, only requesters 1 and 3 valid (tags 0x11, 0x33) →
  - lane0=0x33, lane1=0x11 next cycle;
  - `rr_q` becomes 2.
- **Single request:** only requester 2 valid with data 0xDEADBEEF →
  - `cdb_valid_o`=01, lane0 data 0xDEADBEEF;
  - lane1 tag and data 0;
  - `rr_q`=3.
- **Flush:** all valid, `flush_i` high one cycle →
  - `req_ready_o`=0 that cycle; `cdb_valid_o`=00 next cycle;
  - arbitration resumes from the unchanged `rr_q`.
- **Non-power-of-two:** `NumRequesters`=3, `CDBWidth`=2, all valid → grants {0,1}, {2,0}, {1,2}; no index 3 ever appears.

Source files
------------

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared common-data-bus widths, lane struct and index helper
package cdb_pkg;

    localparam int PhyRegIDWidth = 6;
    localparam int DatapathWidth = 32;
    localparam int CDBWidth      = 2;

    // Lane record as seen by the reorder buffer and reservation stations
    typedef struct packed {
        logic                     valid;
        logic [PhyRegIDWidth-1:0] tag;
        logic [DatapathWidth-1:0] data;
    } cdb_lane_t;

    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - one-hot of the first set request at or after start, wrapping
module cdb_rr_pick #(
    parameter int NumRequesters = 4
) (
    input  logic [NumRequesters-1:0]         req,
    input  logic [$clog2(NumRequesters)-1:0] start,
    output logic [NumRequesters-1:0]         grant
);

    logic found;
    int   idx;

    // Wrap by subtraction so non-power-of-two counts never index past the end
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NumRequesters; off++) begin
            idx = int'(start) + off;
            if (idx >= NumRequesters) begin
                idx = idx - NumRequesters;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter placing up to CDBWidth results per cycle on the CDB
module cdb_arbiter #(
    parameter int NumRequesters = 4,
    parameter int CDBWidth      = cdb_pkg::CDBWidth,
    parameter int PhyRegIDWidth = cdb_pkg::PhyRegIDWidth,
    parameter int DatapathWidth = cdb_pkg::DatapathWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i [NumRequesters-1:0],
    input  logic [PhyRegIDWidth-1:0] req_tag_i   [NumRequesters-1:0],
    input  logic [DatapathWidth-1:0] req_data_i  [NumRequesters-1:0],
    output logic                     req_ready_o [NumRequesters-1:0],
    output logic [CDBWidth-1:0]      cdb_valid_o,
    output logic [PhyRegIDWidth-1:0] cdb_tag_o   [CDBWidth-1:0],
    output logic [DatapathWidth-1:0] cdb_data_o  [CDBWidth-1:0]
);

    localparam int IdxWidth = $clog2(NumRequesters);

    logic [NumRequesters-1:0] req_vec;
    logic [NumRequesters-1:0] ready_vec;
    logic [NumRequesters-1:0] remaining [CDBWidth];
    logic [NumRequesters-1:0] grant     [CDBWidth];
    logic [IdxWidth-1:0]      rr_q;
    logic [IdxWidth-1:0]      rr_d;
    logic [CDBWidth-1:0]      lane_valid_d;
    logic [PhyRegIDWidth-1:0] lane_tag_d  [CDBWidth];
    logic [DatapathWidth-1:0] lane_data_d [CDBWidth];
    int                       last_idx;

    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            req_vec[i] = req_valid_i[i];
        end
    end

    // Each stage sees the requests left over by earlier lanes, all from the same start
    for (genvar k = 0; k < CDBWidth; k++) begin : g_pick
        if (k == 0) begin : g_first
            assign remaining[0] = (rst_i || flush_i) ? '0 : req_vec;
        end else begin : g_next
            assign remaining[k] = remaining[k-1] & ~grant[k-1];
        end
        cdb_rr_pick #(
            .NumRequesters(NumRequesters)
        ) u_pick (
            .req   (remaining[k]),
            .start (rr_q),
            .grant (grant[k])
        );
    end

    always_comb begin
        ready_vec = '0;
        for (int k = 0; k < CDBWidth; k++) begin
            ready_vec = ready_vec | grant[k];
        end
        for (int i = 0; i < NumRequesters; i++) begin
            req_ready_o[i] = ready_vec[i];
        end
    end

    // Lanes fill in scan order, so the last lane written holds the last winner
    always_comb begin
        lane_valid_d = '0;
        last_idx     = 0;
        for (int k = 0; k < CDBWidth; k++) begin
            lane_tag_d[k]  = '0;
            lane_data_d[k] = '0;
            for (int i = 0; i < NumRequesters; i++) begin
                if (grant[k][i]) begin
                    lane_valid_d[k] = 1'b1;
                    lane_tag_d[k]   = req_tag_i[i];
                    lane_data_d[k]  = req_data_i[i];
                    last_idx        = i;
                end
            end
        end
        rr_d = (|lane_valid_d) ? IdxWidth'(cdb_pkg::rr_wrap_inc(last_idx, NumRequesters)) : rr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            cdb_valid_o <= '0;
            for (int k = 0; k < CDBWidth; k++) begin
                cdb_tag_o[k]  <= '0;
                cdb_data_o[k] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            cdb_valid_o <= lane_valid_d;
            for (int k = 0; k < CDBWidth; k++) begin
                cdb_tag_o[k]  <= lane_tag_d[k];
                cdb_data_o[k] <= lane_data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter (4x2 and 3x2 configurations)
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    logic        va  [3:0];
    logic [5:0]  ta  [3:0];
    logic [31:0] da  [3:0];
    logic        ra  [3:0];
    logic [1:0]  cva;
    logic [5:0]  cta [1:0];
    logic [31:0] cda [1:0];

    logic        vb  [2:0];
    logic [5:0]  tb_ [2:0];
    logic [31:0] db  [2:0];
    logic        rb  [2:0];
    logic [1:0]  cvb;
    logic [5:0]  ctb [1:0];
    logic [31:0] cdb [1:0];

    logic [3:0] rpa;
    logic [2:0] rpb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) rpa[i] = ra[i];
        for (int i = 0; i < 3; i++) rpb[i] = rb[i];
    end

    cdb_arbiter #(
        .NumRequesters(4), .CDBWidth(2), .PhyRegIDWidth(6), .DatapathWidth(32)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(va), .req_tag_i(ta), .req_data_i(da), .req_ready_o(ra),
        .cdb_valid_o(cva), .cdb_tag_o(cta), .cdb_data_o(cda)
    );

    cdb_arbiter #(
        .NumRequesters(3), .CDBWidth(2), .PhyRegIDWidth(6), .DatapathWidth(32)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(vb), .req_tag_i(tb_), .req_data_i(db), .req_ready_o(rb),
        .cdb_valid_o(cvb), .cdb_tag_o(ctb), .cdb_data_o(cdb)
    );

    task automatic set_va(input logic [3:0] v);
        for (int i = 0; i < 4; i++) va[i] = v[i];
    endtask

    task automatic set_vb(input logic [2:0] v);
        for (int i = 0; i < 3; i++) vb[i] = v[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_va(4'hF);
        set_vb(3'h7);
        repeat (3) begin
            #1;
            checks++;
            if (rpa !== 4'b0000) begin errors++; $display("FAIL reset_ready_a got %b want 0000", rpa); end
            checks++;
            if (rpb !== 3'b000) begin errors++; $display("FAIL reset_ready_b got %b want 000", rpb); end
            step();
        end
        checks++;
        if (cva !== 2'b00 || cta[0] !== 6'd0 || cda[1] !== 32'd0) begin
            errors++; $display("FAIL reset_lanes got v=%b t0=%h d1=%h want 0", cva, cta[0], cda[1]);
        end
        rst = 1'b0;
        set_vb(3'h0);
        #1;
        checks++;
        if (cva !== 2'b00) begin errors++; $display("FAIL release_valid got %b want 00", cva); end
        checks++;
        if (rpa !== 4'b0011) begin errors++; $display("FAIL release_ready got %b want 0011", rpa); end
    endtask

    task automatic test_round_robin();
        logic [3:0] er [3];
        logic [5:0] e0 [3];
        logic [5:0] e1 [3];
        er = '{4'b0011, 4'b1100, 4'b0011};
        e0 = '{6'd0, 6'd2, 6'd0};
        e1 = '{6'd1, 6'd3, 6'd1};
        set_va(4'hF);
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (rpa !== er[j]) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", j, rpa, er[j]); end
            step();
            checks++;
            if (cva !== 2'b11 || cta[0] !== e0[j] || cta[1] !== e1[j] || cda[0] !== 32'h100 + 32'(e0[j])) begin
                errors++;
                $display("FAIL rr_lanes[%0d] got v=%b t0=%h t1=%h d0=%h want v=11 t0=%h t1=%h", j, cva, cta[0], cta[1], cda[0], e0[j], e1[j]);
            end
        end
    endtask

    task automatic test_single();
        set_va(4'b0100);
        da[2] = 32'hDEADBEEF;
        #1;
        checks++;
        if (rpa !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", rpa); end
        step();
        checks++;
        if (cva !== 2'b01 || cda[0] !== 32'hDEADBEEF || cta[0] !== 6'd2) begin
            errors++; $display("FAIL single_lane0 got v=%b t0=%h d0=%h want v=01 t0=02 d0=deadbeef", cva, cta[0], cda[0]);
        end
        checks++;
        if (cta[1] !== 6'd0 || cda[1] !== 32'd0) begin
            errors++; $display("FAIL single_lane1 got t1=%h d1=%h want 0", cta[1], cda[1]);
        end
        da[2] = 32'h102;
    endtask

    task automatic test_sparse_wrap();
        ta[1] = 6'h11;
        ta[3] = 6'h33;
        set_va(4'b1010);
        #1;
        checks++;
        if (rpa !== 4'b1010) begin errors++; $display("FAIL sparse_ready got %b want 1010", rpa); end
        step();
        checks++;
        if (cva !== 2'b11 || cta[0] !== 6'h33 || cta[1] !== 6'h11) begin
            errors++; $display("FAIL sparse_lanes got v=%b t0=%h t1=%h want v=11 t0=33 t1=11", cva, cta[0], cta[1]);
        end
        ta[1] = 6'd1;
        ta[3] = 6'd3;
    endtask

    task automatic test_flush();
        set_va(4'hF);
        flush = 1'b1;
        #1;
        checks++;
        if (rpa !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", rpa); end
        step();
        checks++;
        if (cva !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", cva); end
        flush = 1'b0;
        #1;
        checks++;
        if (rpa !== 4'b1100) begin errors++; $display("FAIL flush_resume got %b want 1100", rpa); end
        step();
        checks++;
        if (cva !== 2'b11 || cta[0] !== 6'd2 || cta[1] !== 6'd3) begin
            errors++; $display("FAIL flush_lanes got v=%b t0=%h t1=%h want v=11 t0=02 t1=03", cva, cta[0], cta[1]);
        end
    endtask

    task automatic test_back_to_back();
        set_va(4'b0000);
        #1;
        checks++;
        if (rpa !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b want 0000", rpa); end
        step();
        checks++;
        if (cva !== 2'b00) begin errors++; $display("FAIL idle_valid got %b want 00", cva); end
        set_va(4'b1001);
        #1;
        checks++;
        if (rpa !== 4'b1001) begin errors++; $display("FAIL hold_ready got %b want 1001", rpa); end
        step();
        checks++;
        if (cva !== 2'b11 || cta[0] !== 6'd0 || cta[1] !== 6'd3) begin
            errors++; $display("FAIL hold_lanes got v=%b t0=%h t1=%h want v=11 t0=00 t1=03", cva, cta[0], cta[1]);
        end
        set_va(4'hF);
        #1;
        checks++;
        if (rpa !== 4'b0011) begin errors++; $display("FAIL wrap_ready got %b want 0011", rpa); end
        step();
        checks++;
        if (cva !== 2'b11 || cta[0] !== 6'd0 || cda[1] !== 32'h101) begin
            errors++; $display("FAIL b2b_lanes got v=%b t0=%h d1=%h want v=11 t0=00 d1=101", cva, cta[0], cda[1]);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        checks++;
        if (rpa !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", rpa); end
        step();
        checks++;
        if (cva !== 2'b00 || cta[0] !== 6'd0 || cda[0] !== 32'd0) begin
            errors++; $display("FAIL midrst_lanes got v=%b t0=%h d0=%h want 0", cva, cta[0], cda[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rpa !== 4'b0011) begin errors++; $display("FAIL midrst_ptr got %b want 0011", rpa); end
        step();
        set_va(4'h0);
    endtask

    task automatic test_non_pow2();
        logic [2:0] er [3];
        logic [5:0] e0 [3];
        logic [5:0] e1 [3];
        er = '{3'b011, 3'b101, 3'b110};
        e0 = '{6'd0, 6'd2, 6'd1};
        e1 = '{6'd1, 6'd0, 6'd2};
        set_vb(3'h7);
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (rpb !== er[j]) begin errors++; $display("FAIL npot_ready[%0d] got %b want %b", j, rpb, er[j]); end
            step();
            checks++;
            if (cvb !== 2'b11 || ctb[0] !== e0[j] || ctb[1] !== e1[j] || cdb[1] !== 32'h200 + 32'(e1[j])) begin
                errors++;
                $display("FAIL npot_lanes[%0d] got v=%b t0=%h t1=%h d1=%h want t0=%h t1=%h", j, cvb, ctb[0], ctb[1], cdb[1], e0[j], e1[j]);
            end
        end
        set_vb(3'h0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            va[i] = 1'b0;
            ta[i] = 6'(i);
            da[i] = 32'h100 + 32'(i);
        end
        for (int i = 0; i < 3; i++) begin
            vb[i]  = 1'b0;
            tb_[i] = 6'(i);
            db[i]  = 32'h200 + 32'(i);
        end
        test_reset();
        test_round_robin();
        test_single();
        test_sparse_wrap();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_non_pow2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
